dma_periph_req_arb: RTL

// - Parametrised peripheral request front-end for the dma_axi64 channel engine.
// - Replaces the fixed per-direction periph_tx/rx req/clr pairs with NUM_PERIPH request lines.
// - Captures requests in per-line LEVEL or PULSE mode and round-robin arbitrates enabled lines.
// - Hands one request at a time to the channel engine, returns periph_clr on completion,
//   and watchdogs transfers that never complete.

---
 rtl/dma_periph_req_arb_pkg.sv | 14 +
 rtl/dma_periph_req_arb_if.sv | 29 ++
 rtl/dma_periph_req_arb_rr.sv | 30 +++
 rtl/dma_periph_req_arb.sv | 132 +++++++++++++
 4 files changed

// File: rtl/dma_periph_req_arb_pkg.sv
// Shared types and helpers for the DMA peripheral request front-end.
package dma_periph_pkg;

    typedef enum logic {
        REQ_LEVEL = 1'b0,
        REQ_PULSE = 1'b1
    } req_mode_e;

    // Index width for n lines, never narrower than one bit.
    function automatic int id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dma_periph_req_arb_if.sv
// Peripheral request / channel-engine handshake bundle for dma_periph_req_arb.
interface dma_periph_req_arb_if
    import dma_periph_pkg::*;
#(
    parameter int NUM_PERIPH = 8
) ();
    localparam int ID_W = id_w(NUM_PERIPH);

    logic [NUM_PERIPH-1:0] periph_req;
    logic [NUM_PERIPH-1:0] periph_clr;
    logic [NUM_PERIPH-1:0] en_mask;
    logic                  req_valid;
    logic [ID_W-1:0]       req_id;
    logic                  req_ready;
    logic                  done_valid;
    logic [ID_W-1:0]       done_id;
    logic [NUM_PERIPH-1:0] timeout_err;
    logic                  spurious_done;

    modport master (
        output periph_req, en_mask, req_ready, done_valid, done_id,
        input  periph_clr, req_valid, req_id, timeout_err, spurious_done
    );

    modport slave (
        input  periph_req, en_mask, req_ready, done_valid, done_id,
        output periph_clr, req_valid, req_id, timeout_err, spurious_done
    );
endinterface

// File: rtl/dma_periph_req_arb_rr.sv
// Combinational round-robin pick: first eligible line at or after rr_ptr, wrapping.
module dma_rr_arbiter
    import dma_periph_pkg::*;
#(
    parameter int N = 8,
    parameter int ID_W = id_w(N)
) (
    input  logic [N-1:0]    eligible_i,
    input  logic [ID_W-1:0] rr_ptr_i,
    output logic            any_o,
    output logic [ID_W-1:0] grant_id_o
);

    int idx;

    // Scan from the far end so the candidate closest to rr_ptr is written last.
    always_comb begin
        any_o      = 1'b0;
        grant_id_o = '0;
        idx        = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr_i) + k) % N;
            if (eligible_i[idx]) begin
                any_o      = 1'b1;
                grant_id_o = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/dma_periph_req_arb.sv
// Peripheral request capture, round-robin offer to the channel engine, completion clear and watchdog.
module dma_periph_req_arb
    import dma_periph_pkg::*;
#(
    parameter int                    NUM_PERIPH  = 8,
    parameter logic [NUM_PERIPH-1:0] PULSE_MASK  = '0,
    parameter int                    CLR_TIMEOUT = 256,
    parameter int                    TO_W        = $clog2(CLR_TIMEOUT + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    dma_periph_req_arb_if.slave  bus
);

    localparam int N    = NUM_PERIPH;
    localparam int ID_W = id_w(N);

    logic [N-1:0]    pending_q, pending_d;
    logic [N-1:0]    inflight_q, inflight_d;
    logic [N-1:0]    blank_q, blank_d;
    logic [N-1:0]    req_prev_q;
    logic [N-1:0]    periph_clr_q, periph_clr_d;
    logic [N-1:0]    timeout_err_q, timeout_err_d;
    logic            spurious_q, spurious_d;
    logic            req_valid_q, req_valid_d;
    logic [ID_W-1:0] req_id_q, req_id_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [TO_W-1:0] wdog_q [N];
    logic [TO_W-1:0] wdog_d [N];

    logic            hs;
    logic [N-1:0]    hs_sel, done_sel, done_clr, timeout, rise, capture, eligible;
    logic            arb_any;
    logic [ID_W-1:0] arb_id;
    req_mode_e       mode;

    dma_rr_arbiter #(.N(N), .ID_W(ID_W)) u_arb (
        .eligible_i (eligible),
        .rr_ptr_i   (rr_ptr_q),
        .any_o      (arb_any),
        .grant_id_o (arb_id)
    );

    always_comb begin
        hs       = req_valid_q & bus.req_ready;
        hs_sel   = '0;
        done_sel = '0;
        timeout  = '0;
        capture  = '0;
        mode     = REQ_LEVEL;
        for (int i = 0; i < N; i++) begin
            hs_sel[i]   = hs && (req_id_q == ID_W'(i));
            done_sel[i] = bus.done_valid && (bus.done_id == ID_W'(i));
        end
        done_clr   = done_sel & inflight_q;
        spurious_d = spurious_q | (bus.done_valid & ~(|done_clr));

        // A done arriving in the expiry cycle beats the watchdog.
        for (int i = 0; i < N; i++) begin
            timeout[i] = inflight_q[i] && (wdog_q[i] == TO_W'(CLR_TIMEOUT - 1)) && !done_clr[i];
        end
        inflight_d    = (inflight_q & ~done_clr & ~timeout) | hs_sel;
        periph_clr_d  = done_clr | timeout;
        timeout_err_d = timeout;
        blank_d       = periph_clr_q;

        // Level lines stay deaf during the clear pulse and the cycle after it.
        rise = bus.periph_req & ~req_prev_q;
        for (int i = 0; i < N; i++) begin
            mode = req_mode_e'(PULSE_MASK[i]);
            if (mode == REQ_PULSE) begin
                capture[i] = rise[i];
            end else begin
                capture[i] = bus.periph_req[i] & ~blank_q[i] & ~periph_clr_q[i];
            end
        end
        capture   = capture & ~pending_q & ~inflight_q;
        pending_d = (pending_q & ~hs_sel) | capture;
        eligible  = pending_q & bus.en_mask & ~inflight_q;

        req_valid_d = req_valid_q;
        req_id_d    = req_id_q;
        rr_ptr_d    = rr_ptr_q;
        if (hs) begin
            req_valid_d = 1'b0;
            req_id_d    = '0;
            rr_ptr_d    = ID_W'((int'(req_id_q) + 1) % N);
        end else if (!req_valid_q && arb_any) begin
            req_valid_d = 1'b1;
            req_id_d    = arb_id;
        end

        for (int i = 0; i < N; i++) begin
            wdog_d[i] = (inflight_q[i] && inflight_d[i]) ? wdog_q[i] + TO_W'(1) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q     <= '0;
            inflight_q    <= '0;
            blank_q       <= '0;
            req_prev_q    <= '0;
            periph_clr_q  <= '0;
            timeout_err_q <= '0;
            spurious_q    <= 1'b0;
            req_valid_q   <= 1'b0;
            req_id_q      <= '0;
            rr_ptr_q      <= '0;
            wdog_q        <= '{default: '0};
        end else begin
            pending_q     <= pending_d;
            inflight_q    <= inflight_d;
            blank_q       <= blank_d;
            req_prev_q    <= bus.periph_req;
            periph_clr_q  <= periph_clr_d;
            timeout_err_q <= timeout_err_d;
            spurious_q    <= spurious_d;
            req_valid_q   <= req_valid_d;
            req_id_q      <= req_id_d;
            rr_ptr_q      <= rr_ptr_d;
            wdog_q        <= wdog_d;
        end
    end

    assign bus.periph_clr    = periph_clr_q;
    assign bus.timeout_err   = timeout_err_q;
    assign bus.spurious_done = spurious_q;
    assign bus.req_valid     = req_valid_q;
    assign bus.req_id        = req_id_q;

endmodule
